// File: rtl/cam_pattern_gen.sv
// cam_pattern_gen: synthetic OV7670-style camera source.
// Produces pclk, vsync, href and RGB565 byte data with the same framing as the
// real sensor, so the capture chain can be exercised against known frames.
// Timing outputs are registered and only move on the pclk falling edge. They
// are therefore stable around every pclk rising edge, where the capture logic
// samples them.
module cam_pattern_gen #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int H_BLANK     = 144,
   parameter int VSYNC_LINES = 3,
   parameter int V_BACK      = 17,
   parameter int V_FRONT     = 10,
   parameter int CLK_DIV     = 4
)(
   input  logic        i_sysclk,
   input  logic        db_rstn,
   input  logic        i_enable,
   input  logic [1:0]  i_pattern,
   input  logic [15:0] i_solid,
   output logic        o_cam_pclk,
   output logic        o_cam_vsync,
   output logic        o_cam_href,
   output logic [7:0]  o_cam_data,
   output logic        o_sof,
   output logic [15:0] o_frame_count
);

   localparam int LINE  = 2*H_ACTIVE + H_BLANK;
   localparam int FRAME = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
   localparam int HW    = $clog2(LINE + 1);
   localparam int VW    = $clog2(FRAME + 1);
   localparam int DW    = $clog2(CLK_DIV);
   localparam int HALF  = CLK_DIV / 2;
   localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

   localparam logic [HW-1:0] H_LAST      = HW'(LINE - 1);
   localparam logic [HW-1:0] H_ACT_END   = HW'(2*H_ACTIVE);
   localparam logic [HW-1:0] BAR_DIV     = HW'(BAR_W);
   localparam logic [VW-1:0] V_LAST      = VW'(FRAME - 1);
   localparam logic [VW-1:0] V_SYNC_END  = VW'(VSYNC_LINES);
   localparam logic [VW-1:0] V_ACT_START = VW'(VSYNC_LINES + V_BACK);
   localparam logic [VW-1:0] V_ACT_END   = VW'(VSYNC_LINES + V_BACK + V_ACTIVE);
   localparam logic [DW-1:0] DIV_LAST    = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] FALL_CNT    = DW'(HALF - 1);
   localparam logic [DW-1:0] HALF_CNT    = DW'(HALF);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t        r_state;
   logic [DW-1:0] r_divCnt;
   logic          r_pclk;
   logic [HW-1:0] r_h;
   logic [VW-1:0] r_v;
   logic          r_vsync;
   logic          r_href;
   logic [7:0]    r_data;
   logic          r_sof;
   logic [15:0]   r_frameCount;
   logic [1:0]    r_pattern;
   logic [15:0]   r_solid;
   logic [15:0]   r_pixCnt;

   logic [DW-1:0] w_divNext;
   logic          w_fallTick;
   logic [HW-1:0] w_hNext;
   logic [VW-1:0] w_vNext;
   logic          w_runNext;
   logic          w_frameStart;
   logic          w_frameEnd;
   logic          w_vsyncNext;
   logic          w_activeLine;
   logic          w_hrefNext;
   logic [4:0]    w_y5;
   logic [5:0]    w_x6;
   logic [HW-1:0] w_barIdx;
   logic [2:0]    w_bar;
   logic [1:0]    w_patSel;
   logic [15:0]   w_solidSel;
   logic [15:0]   w_barColour;
   logic [15:0]   w_pixel;
   logic [7:0]    w_dataNext;

   // The divider counter is reset to its last count so pclk comes out of reset
   // low and stays equal to (count < CLK_DIV/2) from then on.
   assign w_divNext  = (r_divCnt == DIV_LAST) ? '0 : r_divCnt + 1'b1;
   assign w_fallTick = (r_divCnt == FALL_CNT);

   // Free-running pixel clock divider
   always_ff @(posedge i_sysclk or negedge db_rstn) begin
      if (!db_rstn) begin
         r_divCnt <= DIV_LAST;
         r_pclk   <= 1'b0;
      end else begin
         r_divCnt <= w_divNext;
         r_pclk   <= (w_divNext < HALF_CNT);
      end
   end

   // Raster position that the next fall tick moves to, and whether we keep running
   always_comb begin
      w_hNext      = r_h;
      w_vNext      = r_v;
      w_runNext    = 1'b0;
      w_frameStart = 1'b0;
      if (r_state == S_IDLE) begin
         w_hNext      = '0;
         w_vNext      = '0;
         w_runNext    = i_enable;
         w_frameStart = i_enable;
      end else if (r_h == H_LAST) begin
         w_hNext = '0;
         if (r_v == V_LAST) begin
            w_vNext      = '0;
            w_runNext    = i_enable;
            w_frameStart = i_enable;
         end else begin
            w_vNext   = r_v + 1'b1;
            w_runNext = 1'b1;
         end
      end else begin
         w_hNext   = r_h + 1'b1;
         w_runNext = 1'b1;
      end
   end

   assign w_frameEnd   = (r_state == S_RUN) && (r_h == H_LAST) && (r_v == V_LAST);
   assign w_vsyncNext  = w_runNext && (w_vNext < V_SYNC_END);
   assign w_activeLine = (w_vNext >= V_ACT_START) && (w_vNext < V_ACT_END);
   assign w_hrefNext   = w_runNext && w_activeLine && (w_hNext < H_ACT_END);

   // Pixel coordinates of the upcoming byte; only the low bits feed the gradient
   assign w_y5     = 5'(w_vNext - V_ACT_START);
   assign w_x6     = 6'(w_hNext[HW-1:1]);
   assign w_barIdx = {1'b0, w_hNext[HW-1:1]} / BAR_DIV;
   assign w_bar    = (w_barIdx > HW'(7)) ? 3'd7 : w_barIdx[2:0];

   // A new frame uses the inputs live on its first tick, later ticks use the latched copy
   assign w_patSel   = w_frameStart ? i_pattern : r_pattern;
   assign w_solidSel = w_frameStart ? i_solid   : r_solid;

   // Colour bar palette, leftmost bar first
   always_comb begin
      w_barColour = 16'h0000;
      case (w_bar)
         3'd0:    w_barColour = 16'hFFFF;
         3'd1:    w_barColour = 16'hFFE0;
         3'd2:    w_barColour = 16'h07FF;
         3'd3:    w_barColour = 16'h07E0;
         3'd4:    w_barColour = 16'hF81F;
         3'd5:    w_barColour = 16'hF800;
         3'd6:    w_barColour = 16'h001F;
         default: w_barColour = 16'h0000;
      endcase
   end

   // Pixel value for the selected test pattern
   always_comb begin
      w_pixel = 16'h0000;
      case (w_patSel)
         2'd0:    w_pixel = w_barColour;
         2'd1:    w_pixel = w_solidSel;
         2'd2:    w_pixel = {w_y5, w_x6, w_x6[4:0]};
         default: w_pixel = r_pixCnt;
      endcase
   end

   // High byte on even h, low byte on odd h, zero outside href
   assign w_dataNext = !w_hrefNext ? 8'h00 :
                       (w_hNext[0] ? w_pixel[7:0] : w_pixel[15:8]);

   // Frame state machine: advances the raster and registers all camera outputs on fall ticks
   always_ff @(posedge i_sysclk or negedge db_rstn) begin
      if (!db_rstn) begin
         r_state      <= S_IDLE;
         r_h          <= '0;
         r_v          <= '0;
         r_vsync      <= 1'b0;
         r_href       <= 1'b0;
         r_data       <= 8'h00;
         r_sof        <= 1'b0;
         r_frameCount <= 16'h0000;
         r_pattern    <= 2'd0;
         r_solid      <= 16'h0000;
         r_pixCnt     <= 16'h0000;
      end else begin
         r_sof <= 1'b0;
         if (w_fallTick) begin
            r_state <= w_runNext ? S_RUN : S_IDLE;
            r_h     <= w_hNext;
            r_v     <= w_vNext;
            r_vsync <= w_vsyncNext;
            r_href  <= w_hrefNext;
            r_data  <= w_dataNext;
            r_sof   <= w_vsyncNext & ~r_vsync;
            if (w_frameEnd) begin
               r_frameCount <= r_frameCount + 16'd1;
            end
            if (w_frameStart) begin
               r_pattern <= i_pattern;
               r_solid   <= i_solid;
               r_pixCnt  <= 16'h0000;
            end else if (w_hrefNext && w_hNext[0]) begin
               r_pixCnt <= r_pixCnt + 16'd1;
            end
         end
      end
   end

   assign o_cam_pclk    = r_pclk;
   assign o_cam_vsync   = r_vsync;
   assign o_cam_href    = r_href;
   assign o_cam_data    = r_data;
   assign o_sof         = r_sof;
   assign o_frame_count = r_frameCount;

endmodule

// File: tb/tb_cam_pattern_gen.sv
// tb_cam_pattern_gen: directed bench for cam_pattern_gen on a tiny 8x4 raster.
// Expected bytes are queued as each pattern is requested; a monitor pops and
// compares one byte on every pclk rising edge that has href high.
module tb_cam_pattern_gen;

   localparam int H_ACTIVE    = 8;
   localparam int V_ACTIVE    = 4;
   localparam int H_BLANK     = 4;
   localparam int VSYNC_LINES = 1;
   localparam int V_BACK      = 1;
   localparam int V_FRONT     = 1;
   localparam int CLK_DIV     = 2;

   // 20 pclks per line, 7 lines per frame
   localparam int FRAME_PCLKS = 140;

   logic        i_sysclk = 1'b0;
   logic        db_rstn;
   logic        i_enable;
   logic [1:0]  i_pattern;
   logic [15:0] i_solid;
   logic        o_cam_pclk;
   logic        o_cam_vsync;
   logic        o_cam_href;
   logic [7:0]  o_cam_data;
   logic        o_sof;
   logic [15:0] o_frame_count;

   int          nTests = 0;
   int          nFail  = 0;
   logic [7:0]  expQ[$];

   cam_pattern_gen #(
      .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
      .VSYNC_LINES(VSYNC_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT),
      .CLK_DIV(CLK_DIV)
   ) dut (
      .i_sysclk(i_sysclk),
      .db_rstn(db_rstn),
      .i_enable(i_enable),
      .i_pattern(i_pattern),
      .i_solid(i_solid),
      .o_cam_pclk(o_cam_pclk),
      .o_cam_vsync(o_cam_vsync),
      .o_cam_href(o_cam_href),
      .o_cam_data(o_cam_data),
      .o_sof(o_sof),
      .o_frame_count(o_frame_count)
   );

   // 125 MHz system clock
   always #4 i_sysclk = ~i_sysclk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nTests++;
      if (actual !== expected) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic [1:0] pat, input logic [15:0] solid);
      i_enable  = en;
      i_pattern = pat;
      i_solid   = solid;
   endtask

   task automatic pushCounterFrame();
      logic [15:0] pv;
      for (int p = 0; p < 32; p++) begin
         pv = 16'(p);
         expQ.push_back(pv[15:8]);
         expQ.push_back(pv[7:0]);
      end
   endtask

   task automatic pushBarFrame();
      logic [7:0] lineBytes[16];
      lineBytes = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                    8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
      for (int l = 0; l < V_ACTIVE; l++) begin
         for (int b = 0; b < 16; b++) begin
            expQ.push_back(lineBytes[b]);
         end
      end
   endtask

   task automatic pushSolidFrame(input logic [15:0] s);
      for (int p = 0; p < 32; p++) begin
         expQ.push_back(s[15:8]);
         expQ.push_back(s[7:0]);
      end
   endtask

   task automatic waitSof(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge i_sysclk);
         if (o_sof) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Called on the sample where o_sof was seen; runs until frame_count moves
   task automatic measureFrame(input logic [15:0] fcStart, input bit expectNext);
      int   rises, vsPclks, hrPclks, bursts, sofExtra;
      logic prevP, prevH;
      bit   done;
      rises = 0; vsPclks = 0; hrPclks = 0; bursts = 0; sofExtra = 0;
      prevP = o_cam_pclk;
      prevH = 1'b0;
      done  = 1'b0;
      for (int i = 0; i < 4*FRAME_PCLKS; i++) begin
         @(negedge i_sysclk);
         if (o_frame_count != fcStart) begin
            done = 1'b1;
            break;
         end
         if (o_sof) sofExtra++;
         if (o_cam_pclk && !prevP) begin
            rises++;
            if (o_cam_vsync) vsPclks++;
            if (o_cam_href) begin
               hrPclks++;
               if (!prevH) bursts++;
            end
            prevH = o_cam_href;
         end
         prevP = o_cam_pclk;
      end
      checkOutput("frameDone",   32'(done), 32'd1);
      checkOutput("framePclks",  32'(rises), 32'(FRAME_PCLKS));
      checkOutput("vsyncPclks",  32'(vsPclks), 32'd20);
      checkOutput("hrefPclks",   32'(hrPclks), 32'd64);
      checkOutput("hrefBursts",  32'(bursts), 32'd4);
      checkOutput("sofPerFrame", 32'(sofExtra), 32'd0);
      checkOutput("frameCount",  32'(o_frame_count), 32'(fcStart + 16'd1));
      checkOutput("sofNextFrame", 32'(o_sof), 32'(expectNext));
   endtask

   // Monitor: pops one expected byte per href pclk rise, checks blanking data elsewhere
   initial begin : monitor
      logic       prevPclk;
      logic [7:0] expByte;
      prevPclk = 1'b0;
      forever begin
         @(negedge i_sysclk);
         if (db_rstn && o_cam_pclk && !prevPclk) begin
            if (o_cam_href) begin
               if (expQ.size() == 0) begin
                  nTests++;
                  nFail++;
                  $display("[TB] FAIL byte: got 0x%0h, expected nothing (queue empty) at %0t", o_cam_data, $time);
               end else begin
                  expByte = expQ.pop_front();
                  checkOutput("byte", 32'(o_cam_data), 32'(expByte));
               end
            end else begin
               checkOutput("blankData", 32'(o_cam_data), 32'h00);
            end
         end
         prevPclk = o_cam_pclk;
      end
   end

   // Main sequence
   initial begin : stimulus
      bit   ok;
      int   nonToggle, badOut;
      logic prev;

      db_rstn = 1'b0;
      applyStimulus(1'b0, 2'd0, 16'h0000);
      repeat (3) @(negedge i_sysclk);
      checkOutput("rstPclk",  32'(o_cam_pclk), 32'd0);
      checkOutput("rstVsync", 32'(o_cam_vsync), 32'd0);
      checkOutput("rstHref",  32'(o_cam_href), 32'd0);
      checkOutput("rstData",  32'(o_cam_data), 32'd0);
      checkOutput("rstSof",   32'(o_sof), 32'd0);
      checkOutput("rstFc",    32'(o_frame_count), 32'd0);
      #1 db_rstn = 1'b1;

      // Idle with enable low: pclk runs, everything else stays quiet
      nonToggle = 0;
      badOut    = 0;
      prev      = o_cam_pclk;
      for (int i = 0; i < 100; i++) begin
         @(negedge i_sysclk);
         if (o_cam_pclk == prev) nonToggle++;
         if (o_cam_vsync || o_cam_href || (o_cam_data != 8'h00) || o_sof) badOut++;
         prev = o_cam_pclk;
      end
      checkOutput("idlePclkToggle", 32'(nonToggle), 32'd0);
      checkOutput("idleOutputs",    32'(badOut), 32'd0);
      checkOutput("idleFc",         32'(o_frame_count), 32'd0);

      // Frame 1: pixel counter
      pushCounterFrame();
      #1 applyStimulus(1'b1, 2'd3, 16'h0000);
      waitSof(ok);
      checkOutput("sofFrame1", 32'(ok), 32'd1);
      checkOutput("vsyncAtSof", 32'(o_cam_vsync), 32'd1);
      fork
         measureFrame(16'd0, 1'b1);
         begin
            repeat (40) @(negedge i_sysclk);
            #1 applyStimulus(1'b1, 2'd0, 16'h0000);
            pushBarFrame();
         end
      join

      // Frame 2: colour bars; request solid A5C3 for frame 3
      fork
         measureFrame(16'd1, 1'b1);
         begin
            repeat (40) @(negedge i_sysclk);
            #1 applyStimulus(1'b1, 2'd1, 16'hA5C3);
            pushSolidFrame(16'hA5C3);
         end
      join

      // Frame 3: solid colour changed mid-frame must only show up next frame
      fork
         measureFrame(16'd2, 1'b1);
         begin
            repeat (120) @(negedge i_sysclk);
            #1 applyStimulus(1'b1, 2'd1, 16'h1234);
            pushSolidFrame(16'h1234);
         end
      join

      // Frame 4: enable dropped mid-frame, frame still completes
      fork
         measureFrame(16'd3, 1'b0);
         begin
            repeat (120) @(negedge i_sysclk);
            #1 applyStimulus(1'b0, 2'd1, 16'h1234);
         end
      join
      checkOutput("queueDrained", 32'(expQ.size()), 32'd0);

      badOut = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge i_sysclk);
         if (o_cam_vsync || o_cam_href || o_sof) badOut++;
      end
      checkOutput("idleAfterStop", 32'(badOut), 32'd0);
      checkOutput("fcAfterStop",   32'(o_frame_count), 32'd4);

      // Reset in the middle of an href burst
      pushCounterFrame();
      #1 applyStimulus(1'b1, 2'd3, 16'h0000);
      waitSof(ok);
      checkOutput("sofFrame5", 32'(ok), 32'd1);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge i_sysclk);
         if (o_cam_href) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput("hrefBeforeReset", 32'(ok), 32'd1);
      repeat (5) @(negedge i_sysclk);
      #1 db_rstn = 1'b0;
      #1;
      checkOutput("midRstPclk",  32'(o_cam_pclk), 32'd0);
      checkOutput("midRstVsync", 32'(o_cam_vsync), 32'd0);
      checkOutput("midRstHref",  32'(o_cam_href), 32'd0);
      checkOutput("midRstData",  32'(o_cam_data), 32'd0);
      checkOutput("midRstSof",   32'(o_sof), 32'd0);
      checkOutput("midRstFc",    32'(o_frame_count), 32'd0);
      expQ.delete();
      pushCounterFrame();
      repeat (4) @(negedge i_sysclk);
      #1 db_rstn = 1'b1;

      waitSof(ok);
      checkOutput("sofAfterReset", 32'(ok), 32'd1);
      checkOutput("vsyncAfterReset", 32'(o_cam_vsync), 32'd1);
      fork
         measureFrame(16'd0, 1'b0);
         begin
            repeat (120) @(negedge i_sysclk);
            #1 applyStimulus(1'b0, 2'd3, 16'h0000);
         end
      join
      checkOutput("queueDrainedEnd", 32'(expQ.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
